// File: rtl/spi_temp_reader.sv
// spi_temp_reader
// Read-only SPI master (mode 0) that polls a digital temperature sensor and
// returns its raw 16-bit word. Reads start periodically while enabled, or on
// an explicit request pulse. Each completed word is flagged with a one-cycle
// valid strobe. The word feeds spi_to_temp downstream.
//
// Bus framing per read (all in i_clk cycles):
//   SETUP : CLK_DIV cycles, CS_n low, SCLK low
//   SHIFT : 16 bits x (CLK_DIV low + CLK_DIV high)
//   HOLD  : CLK_DIV cycles, CS_n low, SCLK low
//   GUARD : CLK_DIV cycles, CS_n high (minimum deselect time)
// CS_n is therefore low for exactly 34*CLK_DIV cycles per read.

module spi_temp_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic        i_read_req,
  input  logic        i_spi_miso,
  output logic        o_spi_sclk,
  output logic        o_spi_cs_n,
  output logic [15:0] o_spi_data,
  output logic        o_data_valid,
  output logic        o_busy
);

  // Counter widths derived from the parameters; CLK_DIV=2 still needs one bit.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
  localparam logic [3:0]       BIT_LAST = 4'd15;

  // Transaction state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SETUP = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_GUARD = 3'd4;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;     // cycles spent in the current phase
  logic [3:0]       bit_cnt;     // index of the bit being shifted, 0..15
  logic [15:0]      shift_reg;   // bits collected so far, MSB first
  logic [PER_W-1:0] period_cnt;  // free-running poll timer while enabled
  logic             pend_req;    // request latched from i_read_req
  logic             pend_tmr;    // request latched from the poll timer
  logic             pending;
  logic             start;
  logic             phase_end;

  // Timer-set and user-set requests are tracked separately because disabling
  // polling must drop a timer request but keep an explicit one.
  assign pending   = pend_req | pend_tmr;
  assign start     = (state == ST_IDLE) && pending;
  assign phase_end = (div_cnt == DIV_LAST);

  // Poll timer and request latching; every request source coalesces into one
  // pending read, which is consumed in the cycle the transaction starts.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      period_cnt <= '0;
      pend_req   <= 1'b0;
      pend_tmr   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; later assignments in this block override
      // earlier ones, which is how the start-cycle clear takes priority.
      if (!i_enable) begin
        period_cnt <= '0;
        pend_tmr   <= 1'b0;
      end else if (period_cnt == PER_LAST) begin
        period_cnt <= '0;
        pend_tmr   <= 1'b1;
      end else begin
        period_cnt <= period_cnt + PER_W'(1);
      end

      if (i_read_req) begin
        pend_req <= 1'b1;
      end

      if (start) begin
        pend_req <= 1'b0;
        pend_tmr <= 1'b0;
      end
    end
  end

  // Transaction sequencer: drives CS_n/SCLK, shifts MISO in on each SCLK rise,
  // publishes the word at the CS_n rise and holds off the next read for GUARD.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      o_spi_sclk   <= 1'b0;
      o_spi_cs_n   <= 1'b1;
      o_spi_data   <= '0;
      o_data_valid <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      // NOTE: the strobe defaults low every cycle and is raised only in the
      // publishing cycle, which makes it a single-cycle pulse by construction.
      o_data_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pending) begin
            state      <= ST_SETUP;
            o_spi_cs_n <= 1'b0;
            o_busy     <= 1'b1;
            div_cnt    <= '0;
            bit_cnt    <= '0;
          end
        end

        ST_SETUP: begin
          if (phase_end) begin
            div_cnt <= '0;
            state   <= ST_SHIFT;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_SHIFT: begin
          if (!phase_end) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!o_spi_sclk) begin
              // Rising SCLK: the sensor has had a full low phase to settle.
              o_spi_sclk <= 1'b1;
              shift_reg  <= {shift_reg[14:0], i_spi_miso};
            end else begin
              o_spi_sclk <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                state <= ST_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
        end

        ST_HOLD: begin
          if (phase_end) begin
            div_cnt      <= '0;
            o_spi_cs_n   <= 1'b1;
            o_spi_data   <= shift_reg;
            o_data_valid <= 1'b1;
            state        <= ST_GUARD;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        ST_GUARD: begin
          if (phase_end) begin
            div_cnt <= '0;
            o_busy  <= 1'b0;
            state   <= ST_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: begin
          state      <= ST_IDLE;
          div_cnt    <= '0;
          o_spi_sclk <= 1'b0;
          o_spi_cs_n <= 1'b1;
          o_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_temp_reader.sv
// tb_spi_temp_reader
// Self-checking bench for spi_temp_reader. A sensor model shifts words out on
// SCLK falling edges; a bus monitor records every transaction and every valid
// strobe, and the stimulus thread checks those records against the words the
// sensor actually sent and against the framing rules.

module tb_spi_temp_reader;

  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 1000;
  localparam int CS_LOW_CYCLES = 34 * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        read_req;
  logic        miso = 1'b0;
  logic        spi_sclk;
  logic        spi_cs_n;
  logic [15:0] spi_data;
  logic        data_valid;
  logic        busy;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_temp_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .i_read_req  (read_req),
    .i_spi_miso  (miso),
    .o_spi_sclk  (spi_sclk),
    .o_spi_cs_n  (spi_cs_n),
    .o_spi_data  (spi_data),
    .o_data_valid(data_valid),
    .o_busy      (busy)
  );

  // ---------------- sensor model ----------------
  logic [15:0] word_src[$];   // words the sensor will present, in order
  logic [15:0] sent[$];       // words the sensor actually started sending
  int          src_idx = 0;
  int          bit_idx = 0;
  logic [15:0] cur_word = '0;
  logic        cs_active = 1'b0;

  // MSB is presented as CS_n falls; each SCLK fall presents the next bit.
  always @(negedge spi_cs_n or posedge spi_cs_n or negedge spi_sclk) begin
    if (spi_cs_n !== 1'b0) begin
      cs_active = 1'b0;
    end else if (!cs_active) begin
      cs_active = 1'b1;
      cur_word  = (src_idx < word_src.size()) ? word_src[src_idx] : 16'hDEAD;
      src_idx++;
      sent.push_back(cur_word);
      miso    = cur_word[15];
      bit_idx = 14;
    end else if (bit_idx >= 0) begin
      miso = cur_word[bit_idx];
      bit_idx--;
    end
  end

  // ---------------- bus monitor ----------------
  typedef struct {
    int cs_len;
    int rises;
  } txn_t;

  typedef struct {
    logic [15:0] got;
    logic [15:0] exp;
    logic [1:0]  cs_edge;
  } val_t;

  txn_t txn_q[$];
  val_t val_q[$];
  int   fall_cyc[$];
  int   fall_cnt = 0;
  int   valid_cnt = 0;
  int   last_rise_cyc = 0;
  int   cs_len = 0;
  int   cur_rises = 0;
  int   sclk_bad = 0;
  int   chk_idx = 0;
  logic prev_cs = 1'b1;
  logic prev_sclk = 1'b0;
  logic in_txn = 1'b0;

  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      if (in_txn) chk_idx++;  // aborted read: its word is never delivered
      in_txn    = 1'b0;
      prev_cs   = 1'b1;
      prev_sclk = 1'b0;
    end else begin
      if (prev_cs && !spi_cs_n) begin
        fall_cnt++;
        fall_cyc.push_back(cyc);
        cs_len    = 0;
        cur_rises = 0;
        in_txn    = 1'b1;
      end
      if (!spi_cs_n) begin
        cs_len++;
        if (spi_sclk && !prev_sclk) cur_rises++;
      end
      if (spi_cs_n && !prev_cs) begin
        txn_q.push_back('{cs_len, cur_rises});
        last_rise_cyc = cyc;
        in_txn        = 1'b0;
      end
      if (spi_cs_n && prev_cs && (spi_sclk !== prev_sclk)) sclk_bad++;
      if (data_valid) begin
        valid_cnt++;
        val_q.push_back('{spi_data,
                          (chk_idx < sent.size()) ? sent[chk_idx] : ~spi_data,
                          {prev_cs, spi_cs_n}});
        chk_idx++;
      end
      prev_cs   = spi_cs_n;
      prev_sclk = spi_sclk;
    end
  end

  // ---------------- checking ----------------
  int ti = 0;
  int vi = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Compare every transaction and strobe the monitor recorded since last call.
  task automatic drain();
    while (ti < txn_q.size()) begin
      check("cs_low_cycles", 32'(txn_q[ti].cs_len), 32'(CS_LOW_CYCLES));
      check("sclk_rises", 32'(txn_q[ti].rises), 32'd16);
      ti++;
    end
    while (vi < val_q.size()) begin
      check("valid_data", 32'(val_q[vi].got), 32'(val_q[vi].exp));
      check("valid_at_cs_rise", 32'(val_q[vi].cs_edge), 32'd1);
      vi++;
    end
  endtask

  task automatic pulse_req();
    @(posedge clk);
    #1 read_req = 1'b1;
    @(posedge clk);
    #1 read_req = 1'b0;
  endtask

  task automatic wait_fall(input int max_cyc, input string tag);
    int target;
    int n;
    target = fall_cnt + 1;
    n      = 0;
    while (fall_cnt < target && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(fall_cnt), 32'(target));
  endtask

  task automatic wait_valid(input int max_cyc, input string tag);
    int target;
    int n;
    target = valid_cnt + 1;
    n      = 0;
    while (valid_cnt < target && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(valid_cnt), 32'(target));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int f0;
    int v0;
    int r1;
    int n;

    rst_n    = 1'b0;
    enable   = 1'b0;
    read_req = 1'b0;

    // 1: reset values
    repeat (5) @(posedge clk);
    #1;
    check("rst_cs_n", 32'(spi_cs_n), 32'd1);
    check("rst_sclk", 32'(spi_sclk), 32'd0);
    check("rst_data", 32'(spi_data), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    check("idle_no_reads", 32'(fall_cnt), 32'd0);

    // 2: single requested read with polling off
    word_src.push_back(16'h0A80);
    v0 = valid_cnt;
    pulse_req();
    wait_valid(300, "t2_valid_timeout");
    repeat (200) @(posedge clk);
    drain();
    check("t2_data", 32'(spi_data), 32'h0A80);
    check("t2_temp_c", 32'(spi_data >> 7), 32'd21);
    check("t2_one_valid", 32'(valid_cnt - v0), 32'd1);
    check("t2_busy_done", 32'(busy), 32'd0);

    // 3: periodic polling, three reads 1000 cycles apart
    word_src.push_back(16'h0A60);
    word_src.push_back(16'h0A40);
    word_src.push_back(16'h0A20);
    f0 = fall_cnt;
    @(posedge clk);
    #1 enable = 1'b1;
    repeat (3500) @(posedge clk);
    #1 enable = 1'b0;
    repeat (300) @(posedge clk);
    drain();
    check("t3_read_count", 32'(fall_cnt - f0), 32'(3500 / SAMPLE_PERIOD));
    if (fall_cnt - f0 >= 3) begin
      check("t3_period_1", 32'(fall_cyc[f0 + 1] - fall_cyc[f0]), 32'(SAMPLE_PERIOD));
      check("t3_period_2", 32'(fall_cyc[f0 + 2] - fall_cyc[f0 + 1]), 32'(SAMPLE_PERIOD));
    end
    check("t3_last_word", 32'(spi_data), 32'h0A20);

    // 4: requests during a busy read coalesce into one follow-up read
    word_src.push_back(16'($urandom));
    word_src.push_back(16'($urandom));
    f0 = fall_cnt;
    pulse_req();
    wait_fall(20, "t4_start_timeout");
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(5, 30)) @(posedge clk);
      pulse_req();
    end
    wait_valid(200, "t4_valid1_timeout");
    r1 = last_rise_cyc;
    wait_fall(40, "t4_restart_timeout");
    check("t4_restart_gap", 32'(fall_cyc[fall_cyc.size() - 1] - r1), 32'(CLK_DIV + 1));
    wait_valid(200, "t4_valid2_timeout");
    repeat (400) @(posedge clk);
    drain();
    check("t4_read_count", 32'(fall_cnt - f0), 32'd2);

    // 5: reset in the middle of a read aborts it
    word_src.push_back(16'($urandom));
    v0 = valid_cnt;
    pulse_req();
    wait_fall(20, "t5_start_timeout");
    n = 0;
    while (cur_rises < 8 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("t5_reached_bit8", 32'(cur_rises), 32'd8);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_cs_n_async", 32'(spi_cs_n), 32'd1);
    check("t5_sclk_async", 32'(spi_sclk), 32'd0);
    check("t5_valid_low", 32'(data_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    f0 = fall_cnt;
    repeat (300) @(posedge clk);
    drain();
    check("t5_data_zero", 32'(spi_data), 32'd0);
    check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("t5_no_activity", 32'(fall_cnt - f0), 32'd0);

    // 6: dropping enable mid-read lets it finish, then polling stays off
    word_src.push_back(16'($urandom));
    v0 = valid_cnt;
    @(posedge clk);
    #1 enable = 1'b1;
    wait_fall(SAMPLE_PERIOD + 20, "t6_start_timeout");
    repeat (60) @(posedge clk);
    #1 enable = 1'b0;
    wait_valid(200, "t6_valid_timeout");
    f0 = fall_cnt;
    repeat (2500) @(posedge clk);
    drain();
    check("t6_one_valid", 32'(valid_cnt - v0), 32'd1);
    check("t6_no_more_reads", 32'(fall_cnt - f0), 32'd0);

    // 7: random words back to back, with busy released after the guard
    for (int i = 0; i < 8; i++) begin
      word_src.push_back(16'($urandom));
      pulse_req();
      wait_valid(300, "t7_valid_timeout");
      repeat (CLK_DIV - 1) @(negedge clk);
      check("t7_busy_in_guard", 32'(busy), 32'd1);
      @(negedge clk);
      check("t7_busy_released", 32'(busy), 32'd0);
      repeat ($urandom_range(0, 50)) @(posedge clk);
    end
    repeat (20) @(posedge clk);
    drain();

    check("sclk_quiet_when_cs_high", 32'(sclk_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
